uplink_elink_word_aligner: RTL and testbench
============================================

Name: uplink_elink_word_aligner

Overview:
- Sits directly downstream of the 10G24 multi-uplink lpGBT-FPGA core, one instance per e-link slice.
- Takes one ELINK_WIDTH-bit e-link slice of uplinkUserData_o per 40 MHz frame and assembles WORD_WIDTH-bit TDC words.
- Finds the word boundary by bit-offset search against a fixed idle word, with lock/unlock hysteresis.
- Delivers aligned data words, lock status and error counters to the TDC decoding logic.

Parameters:
- ELINK_WIDTH, 8, bits per frame from the e-link slice; must divide WORD_WIDTH.
- WORD_WIDTH, 32, TDC word width; FPW = WORD_WIDTH/ELINK_WIDTH frames per word (default 4).
- IDLE_WORD, 32'hF0F0_3C5A, idle/alignment word; bits[31:30] must be 2'b11.
- LOCK_COUNT, 8, consecutive idle words needed to lock (range 1..255).
- UNLOCK_COUNT, 4, consecutive bad words that drop lock (range 1..255).

Ports:
- clk_i, in, 1, 40 MHz uplink user clock (uplinkClk_i domain).
- rst_n_i, in, 1, asynchronous active-low reset.
- elink_data_i, in, ELINK_WIDTH, e-link slice; bit ELINK_WIDTH-1 is the oldest bit.
- elink_valid_i, in, 1, frame valid; tied to uplinkReady_o of the link.
- realign_i, in, 1, synchronous pulse that forces SEARCH.
- word_o, out, WORD_WIDTH, aligned data word.
- word_valid_o, out, 1, one-cycle strobe for a data (non-idle) word while LOCKED.
- locked_o, out, 1, high in LOCKED.
- offset_o, out, log2(WORD_WIDTH) (5), current bit offset.
- slip_cnt_o, out, 8, saturating count of offset increments.
- err_cnt_o, out, 16, saturating count of bad words while LOCKED.

Behaviour:
- Reset (async, rst_n_i=0):
  - shift register, fcnt, offset, all counters = 0.
  - state = SEARCH.
  - word_o = 0, word_valid_o = 0, locked_o = 0.
- Shift register:
  - sr is 2*WORD_WIDTH bits; sr <= {sr[2W-ELINK_WIDTH-1:0], elink_data_i}, only when elink_valid_i = 1.
  - elink_valid_i = 0 freezes sr, fcnt and the FSM. word_valid_o = 0 that cycle. Counters and offset hold.
- Boundary:
  - fcnt counts accepted frames 0..FPW-1 and wraps.
  - A boundary is an accepted frame with fcnt = FPW-1.
  - Candidate cw = sr_next[offset+W-1 : offset], where sr_next is sr including the current frame.
- Word classes (hdr = cw[W-1:W-2]):
  - IDLE: cw == IDLE_WORD.
  - DATA: hdr is 01 or 10.
  - BAD: anything else (hdr 00, or hdr 11 but not IDLE_WORD).
- FSM, evaluated only at boundaries:
  - SEARCH: IDLE -> VERIFY, good_cnt = 1. Otherwise offset <= offset+1 (wraps W-1 -> 0), slip_cnt_o++.
  - VERIFY: IDLE -> good_cnt++. When good_cnt+1 reaches LOCK_COUNT -> LOCKED, bad_cnt = 0. Any non-IDLE -> SEARCH, offset++, slip_cnt_o++.
  - LOCKED, IDLE: bad_cnt = 0, no strobe.
  - LOCKED, DATA: word_o <= cw, word_valid_o = 1 next cycle, bad_cnt = 0.
  - LOCKED, BAD: err_cnt_o++, bad_cnt++. When bad_cnt+1 reaches UNLOCK_COUNT -> SEARCH, offset++, slip_cnt_o++.
- LOCK_COUNT = 1: the first IDLE in SEARCH goes directly to LOCKED.
- Latency and outputs:
  - word_o and word_valid_o are registered: they appear 1 clk after the boundary frame is accepted.
  - word_o holds its value between strobes.
  - locked_o is registered and rises/falls in the same cycle as the state change.
- A new offset is first tested at the next boundary, FPW accepted frames later; fcnt is not reset by a slip.
- realign_i = 1: state <= SEARCH and good_cnt = bad_cnt = 0; offset and counters hold. It takes priority over any simultaneous boundary evaluation, and the boundary word is discarded.
- Counters saturate: slip_cnt_o at 255, err_cnt_o at 65535. They clear only on reset.
- No backpressure: word_valid_o is at most one pulse per FPW accepted frames.

Test Plan:
- Aligned idle stream at offset 0, elink_valid_i = 1 -> locked_o = 1 after exactly 8 boundaries (32 frames + 1 clk); slip_cnt_o = 0; offset_o = 0.
- Idle stream delayed by 13 bits -> offset steps through 0..13, slip_cnt_o = 13, locked_o = 1. Then DATA 32'h4123_4567 -> word_o = 32'h4123_4567 with a single word_valid_o pulse 1 clk after its 4th frame.
- Locked; inject 3 BAD words (32'h0000_0001), then DATA, then 4 consecutive BAD words -> err_cnt_o = 7; lock is held after the first three; after the 4th consecutive BAD: locked_o = 0, offset_o = previous offset+1, slip_cnt_o +1.
- Locked; drop elink_valid_i for 5 cycles mid-word, then resume -> word content is unchanged versus the gap-free stream; no spurious word_valid_o; lock is held.
- VERIFY after 5 idles, then one DATA word -> state returns to SEARCH and offset increments. Separately, realign_i on a boundary cycle in LOCKED -> locked_o = 0, no word_valid_o, offset unchanged.
- Async reset mid-word with a forced IDLE pattern at offset 31 -> all outputs 0 immediately. Relock also checks the wrap: starting from offset 31, one slip gives offset 0.

Source files
------------

// File: rtl/uplink_elink_word_aligner.sv
`default_nettype none
// ============================================================================
// Module   : uplink_elink_word_aligner
// Purpose  : Assembles WORD_WIDTH-bit TDC words from one ELINK_WIDTH-bit
//            e-link slice of the lpGBT uplink user data. Finds the word
//            boundary by bit-offset search against a fixed idle word, with
//            lock/unlock hysteresis, and reports data words, lock status and
//            saturating slip/error counters.
// Ports    : clk_i         - uplink user clock (40 MHz)
//            rst_n_i       - asynchronous active-low reset
//            elink_data_i  - e-link slice, MSB is the oldest bit
//            elink_valid_i - frame valid (uplinkReady)
//            realign_i     - synchronous pulse forcing a new search
//            word_o        - last aligned data word (held between strobes)
//            word_valid_o  - one-cycle strobe for a data word while locked
//            locked_o      - high while locked
//            offset_o      - current bit offset of the word window
//            slip_cnt_o    - saturating count of offset increments
//            err_cnt_o     - saturating count of bad words while locked
// Revision : 1.0 - initial release
// ============================================================================
module uplink_elink_word_aligner #(
  parameter int                    ELINK_WIDTH  = 8,
  parameter int                    WORD_WIDTH   = 32,
  parameter logic [WORD_WIDTH-1:0] IDLE_WORD    = 32'hF0F0_3C5A,
  parameter int                    LOCK_COUNT   = 8,
  parameter int                    UNLOCK_COUNT = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic [ELINK_WIDTH-1:0]        elink_data_i,
  input  logic                          elink_valid_i,
  input  logic                          realign_i,
  output logic [WORD_WIDTH-1:0]         word_o,
  output logic                          word_valid_o,
  output logic                          locked_o,
  output logic [$clog2(WORD_WIDTH)-1:0] offset_o,
  output logic [7:0]                    slip_cnt_o,
  output logic [15:0]                   err_cnt_o
);

  localparam int FPW  = WORD_WIDTH / ELINK_WIDTH;
  localparam int FCW  = (FPW > 1) ? $clog2(FPW) : 1;
  localparam int OFFW = $clog2(WORD_WIDTH);
  localparam int SRW  = 2 * WORD_WIDTH;
  localparam int SIW  = $clog2(SRW);

  localparam logic [FCW-1:0]  FCNT_LAST  = FCW'(FPW - 1);
  localparam logic [OFFW-1:0] OFF_LAST   = OFFW'(WORD_WIDTH - 1);
  localparam logic [7:0]      LOCK_THR   = 8'(LOCK_COUNT);
  localparam logic [7:0]      UNLOCK_THR = 8'(UNLOCK_COUNT);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // The oldest frame of the 2W-bit window is shifted out on the same cycle it
  // would become visible, so only 2W-E bits need to be stored.
  logic [SRW-ELINK_WIDTH-1:0] sr_q;
  logic [SRW-1:0]             sr_next;
  logic [FCW-1:0]             fcnt_q;
  logic [OFFW-1:0]            offset_q, offset_d;
  logic [7:0]                 slip_q, slip_d;
  logic [15:0]                err_q, err_d;
  logic [7:0]                 good_q, good_d;
  logic [7:0]                 bad_q, bad_d;
  state_t                     state_q, state_d;
  logic [WORD_WIDTH-1:0]      word_q, word_d;
  logic                       wvalid_q, wvalid_d;
  logic                       locked_q, locked_d;

  logic [SIW-1:0]             cw_idx;
  logic [WORD_WIDTH-1:0]      cw;
  logic                       boundary;
  logic                       is_idle;
  logic                       is_data;
  logic                       do_slip;

  // Candidate word includes the frame being accepted this cycle.
  assign sr_next  = {sr_q, elink_data_i};
  assign cw_idx   = SIW'(offset_q);
  assign cw       = sr_next[cw_idx +: WORD_WIDTH];
  assign boundary = elink_valid_i && (fcnt_q == FCNT_LAST);
  assign is_idle  = (cw == IDLE_WORD);
  assign is_data  = cw[WORD_WIDTH-1] ^ cw[WORD_WIDTH-2];

  always_comb begin
    state_d  = state_q;
    good_d   = good_q;
    bad_d    = bad_q;
    offset_d = offset_q;
    slip_d   = slip_q;
    err_d    = err_q;
    word_d   = word_q;
    wvalid_d = 1'b0;
    do_slip  = 1'b0;

    if (realign_i) begin
      // Realign wins over a coincident boundary; that word is dropped.
      state_d = ST_SEARCH;
      good_d  = 8'd0;
      bad_d   = 8'd0;
    end else if (boundary) begin
      case (state_q)
        ST_SEARCH: begin
          if (is_idle) begin
            good_d = 8'd1;
            if (LOCK_THR <= 8'd1) begin
              state_d = ST_LOCKED;
              bad_d   = 8'd0;
            end else begin
              state_d = ST_VERIFY;
            end
          end else begin
            do_slip = 1'b1;
          end
        end
        ST_VERIFY: begin
          if (is_idle) begin
            good_d = good_q + 8'd1;
            if ((good_q + 8'd1) >= LOCK_THR) begin
              state_d = ST_LOCKED;
              bad_d   = 8'd0;
            end
          end else begin
            state_d = ST_SEARCH;
            good_d  = 8'd0;
            do_slip = 1'b1;
          end
        end
        ST_LOCKED: begin
          if (is_idle) begin
            bad_d = 8'd0;
          end else if (is_data) begin
            word_d   = cw;
            wvalid_d = 1'b1;
            bad_d    = 8'd0;
          end else begin
            err_d = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;
            if ((bad_q + 8'd1) >= UNLOCK_THR) begin
              state_d = ST_SEARCH;
              bad_d   = 8'd0;
              good_d  = 8'd0;
              do_slip = 1'b1;
            end else begin
              bad_d = bad_q + 8'd1;
            end
          end
        end
        default: begin
          state_d = ST_SEARCH;
        end
      endcase
    end

    if (do_slip) begin
      offset_d = (offset_q == OFF_LAST) ? '0 : offset_q + 1'b1;
      slip_d   = (slip_q == 8'hFF) ? slip_q : slip_q + 8'd1;
    end

    locked_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sr_q     <= '0;
      fcnt_q   <= '0;
      state_q  <= ST_SEARCH;
      good_q   <= 8'd0;
      bad_q    <= 8'd0;
      offset_q <= '0;
      slip_q   <= 8'd0;
      err_q    <= 16'd0;
      word_q   <= '0;
      wvalid_q <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      if (elink_valid_i) begin
        sr_q   <= sr_next[SRW-ELINK_WIDTH-1:0];
        fcnt_q <= (fcnt_q == FCNT_LAST) ? '0 : fcnt_q + 1'b1;
      end
      state_q  <= state_d;
      good_q   <= good_d;
      bad_q    <= bad_d;
      offset_q <= offset_d;
      slip_q   <= slip_d;
      err_q    <= err_d;
      word_q   <= word_d;
      wvalid_q <= wvalid_d;
      locked_q <= locked_d;
    end
  end

  assign word_o       = word_q;
  assign word_valid_o = wvalid_q;
  assign locked_o     = locked_q;
  assign offset_o     = offset_q;
  assign slip_cnt_o   = slip_q;
  assign err_cnt_o    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_uplink_elink_word_aligner.sv
`default_nettype none
// ============================================================================
// Module   : tb_uplink_elink_word_aligner
// Purpose  : Self-checking bench for uplink_elink_word_aligner. A bit-level
//            model (history of received bits, window taken by offset) is
//            compared against the DUT every cycle; directed scenarios add
//            hand-computed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uplink_elink_word_aligner;

  localparam logic [31:0] IDLE = 32'hF0F0_3C5A;
  localparam int LOCK_N   = 8;
  localparam int UNLOCK_N = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  elink_data = 8'h00;
  logic        elink_valid = 1'b0;
  logic        realign = 1'b0;
  logic [31:0] word_o;
  logic        word_valid_o;
  logic        locked_o;
  logic [4:0]  offset_o;
  logic [7:0]  slip_cnt_o;
  logic [15:0] err_cnt_o;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  uplink_elink_word_aligner dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .elink_data_i  (elink_data),
    .elink_valid_i (elink_valid),
    .realign_i     (realign),
    .word_o        (word_o),
    .word_valid_o  (word_valid_o),
    .locked_o      (locked_o),
    .offset_o      (offset_o),
    .slip_cnt_o    (slip_cnt_o),
    .err_cnt_o     (err_cnt_o)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------- model
  bit          hist[$];   // received bits, newest at the back, 64 kept
  int          m_frames, m_mode, m_good, m_bad, m_off, m_slip, m_err;
  logic [31:0] m_word;
  bit          m_valid, m_locked;

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < 64; i++) hist.push_back(1'b0);
    m_frames = 0; m_mode = 0; m_good = 0; m_bad = 0;
    m_off = 0; m_slip = 0; m_err = 0;
    m_word = '0; m_valid = 0; m_locked = 0;
  endtask

  task automatic model_slip();
    m_off = (m_off + 1) % 32;
    if (m_slip < 255) m_slip++;
  endtask

  task automatic model_step();
    logic [31:0] cw;
    bit bnd;
    bnd = 0;
    m_valid = 0;
    if (elink_valid) begin
      for (int b = 7; b >= 0; b--) hist.push_back(elink_data[b]);
      while (hist.size() > 64) hist.delete(0);
      m_frames++;
      bnd = ((m_frames % 4) == 0);
    end
    if (realign) begin
      m_mode = 0; m_good = 0; m_bad = 0;
    end else if (bnd) begin
      for (int i = 0; i < 32; i++) cw[i] = hist[63 - m_off - i];
      if (m_mode == 0) begin
        if (cw == IDLE) begin
          m_good = 1;
          m_mode = (m_good >= LOCK_N) ? 2 : 1;
          m_bad  = 0;
        end else model_slip();
      end else if (m_mode == 1) begin
        if (cw == IDLE) begin
          m_good++;
          if (m_good >= LOCK_N) begin m_mode = 2; m_bad = 0; end
        end else begin
          m_mode = 0; m_good = 0; model_slip();
        end
      end else begin
        if (cw == IDLE) m_bad = 0;
        else if (cw[31] != cw[30]) begin
          m_word = cw; m_valid = 1; m_bad = 0;
        end else begin
          if (m_err < 65535) m_err++;
          m_bad++;
          if (m_bad >= UNLOCK_N) begin
            m_mode = 0; m_bad = 0; m_good = 0; model_slip();
          end
        end
      end
    end
    m_locked = (m_mode == 2);
  endtask

  always @(posedge clk) begin
    if (!rst_n) model_reset();
    else        model_step();
    #1;
    n_checks++;
    if (word_o === m_word && word_valid_o === m_valid && locked_o === m_locked &&
        offset_o === 5'(m_off) && slip_cnt_o === 8'(m_slip) && err_cnt_o === 16'(m_err))
      n_pass++;
    else begin
      n_fail++;
      $display("FAIL cycle_model t=%0t dut: word=%h v=%b lk=%b off=%0d slip=%0d err=%0d | expected: word=%h v=%b lk=%b off=%0d slip=%0d err=%0d",
               $time, word_o, word_valid_o, locked_o, offset_o, slip_cnt_o, err_cnt_o,
               m_word, m_valid, m_locked, m_off, m_slip, m_err);
    end
  end

  // ------------------------------------------------------------ stimulus
  bit          bq[$];     // pending bit stream, oldest at the front
  int          vpulses, falls, fall_off, fall_slip;
  bit          prev_locked;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_bits(input logic [31:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) bq.push_back(w[i]);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic v, input logic ra);
    @(negedge clk);
    elink_data = d; elink_valid = v; realign = ra;
    @(posedge clk);
    #2;
    if (word_valid_o) vpulses++;
    if (prev_locked && !locked_o) begin
      falls++; fall_off = offset_o; fall_slip = slip_cnt_o;
    end
    prev_locked = locked_o;
  endtask

  task automatic pop_frame(output logic [7:0] d);
    for (int b = 7; b >= 0; b--) begin d[b] = bq[0]; bq.delete(0); end
  endtask

  task automatic drain(input int max_frames, input int gap_after);
    logic [7:0] d;
    int k;
    k = 0;
    while (bq.size() >= 8 && k < max_frames) begin
      pop_frame(d);
      send_frame(d, 1'b1, 1'b0);
      k++;
      if (k == gap_after) repeat (5) send_frame(8'hC3, 1'b0, 1'b0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; elink_valid = 1'b0; realign = 1'b0;
    bq.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    vpulses = 0; falls = 0; fall_off = -1; fall_slip = -1; prev_locked = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] d;
    int p0;

    // 1: aligned idle stream, lock after exactly 8 boundaries
    do_reset();
    check("reset_word", word_o, 32'h0);
    check("reset_locked", {31'b0, locked_o}, 32'h0);
    check("reset_offset", {27'b0, offset_o}, 32'h0);
    for (int i = 0; i < 8; i++) push_bits(IDLE, 32);
    drain(31, -1);
    check("lock_not_yet_31f", {31'b0, locked_o}, 32'h0);
    drain(1, -1);
    check("lock_at_32f", {31'b0, locked_o}, 32'h1);
    check("aligned_slip", {24'b0, slip_cnt_o}, 32'h0);
    check("aligned_offset", {27'b0, offset_o}, 32'h0);

    // 2: word boundary sits at offset 13 (19-bit idle tail first)
    do_reset();
    push_bits(IDLE, 19);
    for (int i = 0; i < 22; i++) push_bits(IDLE, 32);
    drain(1000, -1);
    check("skew_locked", {31'b0, locked_o}, 32'h1);
    check("skew_offset", {27'b0, offset_o}, 32'd13);
    check("skew_slip", {24'b0, slip_cnt_o}, 32'd13);
    p0 = vpulses;
    push_bits(32'h4123_4567, 32);
    push_bits(IDLE, 32); push_bits(IDLE, 32);
    drain(1000, -1);
    check("data_word", word_o, 32'h4123_4567);
    check("data_pulses", 32'(vpulses - p0), 32'd1);

    // 3: 3 BAD, DATA, 4 BAD -> unlock with one slip
    p0 = vpulses;
    for (int i = 0; i < 3; i++) push_bits(32'h0000_0001, 32);
    push_bits(32'h8000_00AA, 32);
    for (int i = 0; i < 4; i++) push_bits(32'h0000_0001, 32);
    push_bits(IDLE, 32); push_bits(IDLE, 32);
    drain(1000, -1);
    check("bad_err_cnt", {16'b0, err_cnt_o}, 32'd7);
    check("bad_data_pulse", 32'(vpulses - p0), 32'd1);
    check("bad_word_held", word_o, 32'h8000_00AA);
    check("bad_falls", 32'(falls), 32'd1);
    check("bad_fall_offset", 32'(fall_off), 32'd14);
    check("bad_fall_slip", 32'(fall_slip), 32'd14);

    // 4: valid gap mid-word while locked
    do_reset();
    for (int i = 0; i < 8; i++) push_bits(IDLE, 32);
    drain(1000, -1);
    p0 = vpulses;
    push_bits(32'h5A5A_1234, 32);
    drain(1000, 2);
    check("gap_word", word_o, 32'h5A5A_1234);
    check("gap_pulses", 32'(vpulses - p0), 32'd1);
    check("gap_locked", {31'b0, locked_o}, 32'h1);

    // 5a: VERIFY broken by a data word
    do_reset();
    for (int i = 0; i < 5; i++) push_bits(IDLE, 32);
    push_bits(32'h4000_0001, 32);
    drain(1000, -1);
    check("verify_break_offset", {27'b0, offset_o}, 32'd1);
    check("verify_break_slip", {24'b0, slip_cnt_o}, 32'd1);
    check("verify_break_locked", {31'b0, locked_o}, 32'h0);

    // 5b: realign on a locked boundary cycle
    do_reset();
    for (int i = 0; i < 8; i++) push_bits(IDLE, 32);
    drain(1000, -1);
    p0 = vpulses;
    push_bits(32'h6000_0002, 32);
    for (int i = 0; i < 3; i++) begin pop_frame(d); send_frame(d, 1'b1, 1'b0); end
    pop_frame(d); send_frame(d, 1'b1, 1'b1);
    send_frame(8'h00, 1'b0, 1'b0);
    check("realign_locked", {31'b0, locked_o}, 32'h0);
    check("realign_pulses", 32'(vpulses - p0), 32'd0);
    check("realign_offset", {27'b0, offset_o}, 32'd0);

    // 6: lock at offset 31, wrap on unlock, async reset mid-word
    do_reset();
    push_bits(IDLE, 1);
    for (int i = 0; i < 40; i++) push_bits(IDLE, 32);
    drain(1000, -1);
    check("off31_locked", {31'b0, locked_o}, 32'h1);
    check("off31_offset", {27'b0, offset_o}, 32'd31);
    check("off31_slip", {24'b0, slip_cnt_o}, 32'd31);
    for (int i = 0; i < 4; i++) push_bits(32'h0000_0001, 32);
    push_bits(IDLE, 32); push_bits(IDLE, 32);
    drain(1000, -1);
    check("wrap_fall_offset", 32'(fall_off), 32'd0);
    check("wrap_fall_slip", 32'(fall_slip), 32'd32);
    push_bits(IDLE, 32);
    drain(2, -1);
    rst_n = 1'b0;
    #1;
    check("async_rst_word", word_o, 32'h0);
    check("async_rst_flags", {30'b0, word_valid_o, locked_o}, 32'h0);
    check("async_rst_offset", {27'b0, offset_o}, 32'h0);
    check("async_rst_cnts", {slip_cnt_o, err_cnt_o}, 24'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    send_frame(8'h00, 1'b0, 1'b0);
    send_frame(8'h00, 1'b0, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
